// File: rtl/load_store_unit_if.sv
// Bundle of pipeline-request, status and data-memory signals for the load/store unit.
// The master side is the pipeline plus memory; the slave side is the LSU itself.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        misalign;
  logic [31:0] load_data;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  stall, done, misalign, load_data, mem_address, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output stall, done, misalign, load_data, mem_address, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte-to-word address conversion, sub-word load
// extraction with sign/zero extension, and read-modify-write for sb/sh.
module load_store_unit #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  localparam int AW = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, LOAD_RESP, RMW_MERGE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     load_q, load_d;

  // Byte-address bits above the word index wrap and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:AW];

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) r[8*lane +: 8] = wd[7:0];
    else if (lane[1])  r[31:16] = wd;
    else               r[15:0]  = wd;
    return r;
  endfunction

  // State, latched request and held load result; all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      load_q  <= load_d;
    end
  end

  // Next-state, request latching and all bus outputs; outputs forced low during reset.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    uns_d           = uns_q;
    load_d          = load_q;
    bus.stall       = 1'b0;
    bus.done        = 1'b0;
    bus.misalign    = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = '0;
    bus.load_data   = load_q;
    bus.mem_address = {{(32-ADDR_W){1'b0}}, addr_q[AW-1:2]};

    case (state_q)
      IDLE: begin
        bus.mem_address = {{(32-ADDR_W){1'b0}}, bus.req_addr[AW-1:2]};
        if (bus.req_valid) begin
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            bus.misalign = 1'b1;
          end else begin
            addr_d  = bus.req_addr[AW-1:0];
            wdata_d = bus.req_wdata[15:0];
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            if (bus.req_write && bus.req_size == 2'b10) begin
              // Full-word store needs no read: complete in the request cycle.
              bus.mem_write = 1'b1;
              bus.mem_wdata = bus.req_wdata;
              bus.done      = 1'b1;
            end else begin
              bus.mem_read = 1'b1;
              bus.stall    = 1'b1;
              state_d      = bus.req_write ? RMW_MERGE : LOAD_RESP;
            end
          end
        end
      end
      LOAD_RESP: begin
        load_d        = extend_lane(bus.mem_rdata, addr_q[1:0], size_q, uns_q);
        bus.load_data = load_d;
        bus.done      = 1'b1;
        state_d       = IDLE;
      end
      RMW_MERGE: begin
        bus.mem_wdata = merge_lane(bus.mem_rdata, addr_q[1:0], size_q, wdata_q);
        bus.mem_write = 1'b1;
        bus.done      = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      bus.stall       = 1'b0;
      bus.done        = 1'b0;
      bus.misalign    = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_wdata   = '0;
      bus.load_data   = '0;
      bus.mem_address = '0;
    end
  end

endmodule
